// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM type, default 1080p60 raster and sizing helper for the display window driver
package disp_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RUN, DRAIN} state_t;
   localparam int DEF_H_TOTAL = 2200;
   localparam int DEF_H_SYNC  = 44;
   localparam int DEF_H_BP    = 148;
   localparam int DEF_H_ACT   = 1920;
   localparam int DEF_V_TOTAL = 1125;
   localparam int DEF_V_SYNC  = 5;
   localparam int DEF_V_BP    = 36;
   localparam int DEF_V_ACT   = 1080;
   localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BP;
   localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BP;
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/disp_timing_gen.sv
// disp_timing_gen: raster h/v counters with sync, active area, active-relative coordinates and frame/line strobes
module disp_timing_gen
   import disp_pkg::*;
#(
   parameter int H_TOTAL    = DEF_H_TOTAL,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int H_ACT      = DEF_H_ACT,
   parameter bit H_SYNC_POL = 1'b1,
   parameter int V_TOTAL    = DEF_V_TOTAL,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int V_ACT      = DEF_V_ACT,
   parameter bit V_SYNC_POL = 1'b1,
   parameter int CW         = 12
) (
   input  logic          pixel_clock,
   input  logic          reset_n,
   output logic          hsync,
   output logic          vsync,
   output logic          active,
   output logic [CW-1:0] px,
   output logic [CW-1:0] py,
   output logic          frame_start,
   output logic          line_start
);
   localparam int HW    = clog2(H_TOTAL);
   localparam int VW    = clog2(V_TOTAL);
   localparam int H_BEG = H_SYNC + H_BP;
   localparam int V_BEG = V_SYNC + V_BP;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          h_act;
   logic          v_act;
   always_ff @(posedge pixel_clock or negedge reset_n)
      if (!reset_n) begin
         h <= '0;
         v <= '0;
      end else begin
         h <= (h == HW'(H_TOTAL - 1)) ? '0 : h + 1'b1;
         if (h == HW'(H_TOTAL - 1)) v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
      end
   always_comb begin
      h_act       = (int'(h) >= H_BEG) && (int'(h) < H_BEG + H_ACT);
      v_act       = (int'(v) >= V_BEG) && (int'(v) < V_BEG + V_ACT);
      hsync       = (int'(h) < H_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       = (int'(v) < V_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
      active      = h_act && v_act;
      px          = CW'(int'(h) - H_BEG);
      py          = CW'(int'(v) - V_BEG);
      frame_start = (h == '0) && (v == '0);
      line_start  = (h == '0) && v_act;
   end
endmodule

// File: rtl/disp_window_driver.sv
// disp_window_driver: scan-out driver placing a FIFO-fed window in the raster, padding with background colour.
// Optional per-frame underflow statistics counter enabled by defining DISP_UNDERFLOW_STAT_EN.
module disp_window_driver
   import disp_pkg::*;
#(
   parameter int FIFO_DW    = 32,
   parameter int PIX_W      = 24,
   parameter int RD_LAT     = 1,
   parameter int H_TOTAL    = DEF_H_TOTAL,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int H_ACT      = DEF_H_ACT,
   parameter bit H_SYNC_POL = 1'b1,
   parameter int V_TOTAL    = DEF_V_TOTAL,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int V_ACT      = DEF_V_ACT,
   parameter bit V_SYNC_POL = 1'b1,
   parameter int CW         = 12
) (
   input  logic               pixel_clock,
   input  logic               reset_n,
   input  logic [CW-1:0]      win_x,
   input  logic [CW-1:0]      win_y,
   input  logic [CW-1:0]      win_w,
   input  logic [CW-1:0]      win_h,
   input  logic [PIX_W-1:0]   bg_color,
   output logic               rd_load,
   output logic               rdfifo_rden,
   input  logic               rdfifo_empty,
   input  logic [FIFO_DW-1:0] rdfifo_dout,
   output logic               video_hsync,
   output logic               video_vsync,
   output logic               video_den,
   output logic               video_line_start,
   output logic [PIX_W-1:0]   video_pixel,
   output logic               underflow
`ifdef DISP_UNDERFLOW_STAT_EN
   ,
   output logic [15:0]        underflow_cnt
`endif
);
   localparam int PW = PIX_W + 5;
   localparam logic [PW-1:0] PIPE_RST = {~H_SYNC_POL, ~V_SYNC_POL, 3'b000, {PIX_W{1'b0}}};
   logic             hsync;
   logic             vsync;
   logic             active;
   logic             frame_start;
   logic             line_start;
   logic [CW-1:0]    px;
   logic [CW-1:0]    py;
   logic [CW-1:0]    sx;
   logic [CW-1:0]    sy;
   logic [CW-1:0]    sw;
   logic [CW-1:0]    sh;
   logic [PIX_W-1:0] sbg;
   logic [CW:0]      x_end;
   logic [CW:0]      y_end;
   logic             in_win;
   logic             set_uf;
   logic             den_d;
   logic             sel_d;
   logic [PIX_W-1:0] bg_d;
   logic [PW-1:0]    pipe [RD_LAT];
   logic             unused_dout;
   state_t           state;
   state_t           state_nx;

   disp_timing_gen #(
      .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_SYNC_POL(H_SYNC_POL),
      .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_SYNC_POL(V_SYNC_POL),
      .CW(CW)
   ) u_timing (
      .pixel_clock (pixel_clock),
      .reset_n     (reset_n),
      .hsync       (hsync),
      .vsync       (vsync),
      .active      (active),
      .px          (px),
      .py          (py),
      .frame_start (frame_start),
      .line_start  (line_start)
   );

   // window geometry and colour only change at frame start so a frame is never torn
   always_ff @(posedge pixel_clock or negedge reset_n)
      if (!reset_n) begin
         {sx, sy, sw, sh} <= '0;
         sbg              <= '0;
         rd_load          <= 1'b0;
      end else begin
         if (frame_start) {sx, sy, sw, sh, sbg} <= {win_x, win_y, win_w, win_h, bg_color};
         rd_load <= frame_start;
      end

   assign x_end  = {1'b0, sx} + {1'b0, sw};
   assign y_end  = {1'b0, sy} + {1'b0, sh};
   assign in_win = active && (px >= sx) && ({1'b0, px} < x_end) && (py >= sy) && ({1'b0, py} < y_end);

   always_ff @(posedge pixel_clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (rd_load) state_nx = WAIT;
         WAIT:    if (frame_start) state_nx = RUN;
         RUN:     if (in_win && rdfifo_empty) state_nx = DRAIN;
         DRAIN:   if (frame_start) state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      rdfifo_rden = (state == RUN) && in_win && !rdfifo_empty;
      set_uf      = (state == RUN) && in_win && rdfifo_empty;
   end

   always_ff @(posedge pixel_clock or negedge reset_n)
      if (!reset_n) underflow <= 1'b0;
      else if (rd_load) underflow <= 1'b0;
      else if (set_uf) underflow <= 1'b1;

`ifdef DISP_UNDERFLOW_STAT_EN
   always_ff @(posedge pixel_clock or negedge reset_n)
      if (!reset_n) underflow_cnt <= '0;
      else if (rd_load && underflow && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
`endif

   // timing and the read/background choice travel alongside the FIFO read latency
   always_ff @(posedge pixel_clock or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= PIPE_RST;
      end else begin
         pipe[0] <= {hsync, vsync, active, line_start, rdfifo_rden, sbg};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end

   assign {video_hsync, video_vsync, den_d, video_line_start, sel_d, bg_d} = pipe[RD_LAT-1];
   assign video_den   = den_d;
   assign video_pixel = !den_d ? '0 : sel_d ? rdfifo_dout[FIFO_DW-1 -: PIX_W] : bg_d;
   assign unused_dout = ^rdfifo_dout;
endmodule

// File: tb/tb_disp_window_driver.sv
// tb_disp_window_driver: scoreboard bench on a 20x12 raster (12x8 active) with a 3-cycle FIFO read latency
module tb_disp_window_driver;
   localparam int LAT = 3;
   localparam int CW  = 12;
   typedef struct {
      int reads;
      bit uf;
   } frame_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] win_x = 0, win_y = 0, win_w = 12, win_h = 8;
   logic [23:0]   bg_color = 24'h123456;
   logic          rd_load, rden, den, hs, vs, ls, underflow;
   logic          empty = 1'b0;
   logic [31:0]   dout;
   logic [23:0]   pix;
`ifdef DISP_UNDERFLOW_STAT_EN
   logic [15:0]   uf_cnt;
`endif
   int            total = 0, bad = 0;
   logic [23:0]   pix_q[$];
   frame_t        frm_q[$];
   frame_t        f_exp;
   int            nxt_lim = -1, cur_lim = -1, reads = 0, ptr = 0;
   int            hs_n = 0, vs_n = 0, ls_n = 0, n;
   bit            seen = 0, prev_load = 0;
   logic [31:0]   dline [LAT];

   always #5 clk = ~clk;

   disp_window_driver #(
      .FIFO_DW(32), .PIX_W(24), .RD_LAT(LAT),
      .H_TOTAL(20), .H_SYNC(2), .H_BP(2), .H_ACT(12), .H_SYNC_POL(1'b1),
      .V_TOTAL(12), .V_SYNC(1), .V_BP(1), .V_ACT(8), .V_SYNC_POL(1'b1),
      .CW(CW)
   ) dut (
      .pixel_clock      (clk),
      .reset_n          (rst_n),
      .win_x            (win_x),
      .win_y            (win_y),
      .win_w            (win_w),
      .win_h            (win_h),
      .bg_color         (bg_color),
      .rd_load          (rd_load),
      .rdfifo_rden      (rden),
      .rdfifo_empty     (empty),
      .rdfifo_dout      (dout),
      .video_hsync      (hs),
      .video_vsync      (vs),
      .video_den        (den),
      .video_line_start (ls),
      .video_pixel      (pix),
      .underflow        (underflow)
`ifdef DISP_UNDERFLOW_STAT_EN
      ,
      .underflow_cnt    (uf_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO model: flushed by rd_load, data word k carries pixel A0_kkkk, goes empty after cur_lim reads
   always @(posedge clk) begin
      if (rd_load) begin
         ptr     <= 0;
         reads   <= 0;
         cur_lim <= nxt_lim;
      end else if (rden) begin
         ptr   <= ptr + 1;
         reads <= reads + 1;
      end
      dline[0] <= rden ? {8'hA0, ptr[15:0], 8'h5A} : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) dline[i] <= dline[i-1];
   end
   assign dout = dline[LAT-1];

   always @(negedge clk) empty = (cur_lim >= 0) && (reads >= cur_lim);

   // monitor: pops pixel expectations on den, frame statistics on each rd_load
   always @(negedge clk) if (rst_n) begin
      if (den) begin
         if (pix_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pixel_extra: got %h with no expected pixel queued", pix);
         end else chk("pixel", 32'(pix), 32'(pix_q.pop_front()));
      end else chk("pixel_blank", 32'(pix), 32'd0);
      if (prev_load) chk("uf_clear", 32'(underflow), 32'd0);
      if (rd_load) begin
         if (seen) begin
            if (frm_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL frame_extra: got frame end with no expected frame queued");
            end else begin
               f_exp = frm_q.pop_front();
               chk("reads", 32'(reads), 32'(f_exp.reads));
               chk("underflow", 32'(underflow), 32'(f_exp.uf));
               chk("hsync_n", 32'(hs_n), 32'd24);
               chk("vsync_n", 32'(vs_n), 32'd20);
               chk("line_start_n", 32'(ls_n), 32'd8);
            end
         end
         seen = 1;
         hs_n = 0;
         vs_n = 0;
         ls_n = 0;
      end
      hs_n += int'(hs);
      vs_n += int'(vs);
      ls_n += int'(ls);
      prev_load = rd_load;
   end

   task automatic push_frame(input int x, input int y, input int w, input int h,
                             input logic [23:0] bg, input int lim, input bit run);
      int k, cnt;
      bit inw;
      frame_t f;
      k = 0;
      cnt = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 12; c++) begin
            inw = (c >= x) && (c < x + w) && (r >= y) && (r < y + h);
            cnt += int'(inw);
            if (run && inw && (lim < 0 || k < lim)) begin
               pix_q.push_back({8'hA0, 16'(k)});
               k++;
            end else pix_q.push_back(bg);
         end
      f.reads = k;
      f.uf    = run && lim >= 0 && lim < cnt;
      frm_q.push_back(f);
   endtask

   task automatic wait_load();
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!rd_load && c < 400);
      if (!rd_load) begin
         total++;
         bad++;
         $display("FAIL rd_load_timeout: got no rd_load in %0d cycles, expected one per 240", c);
      end
   endtask

   // config is changed mid-frame; it must only take effect at the following frame
   task automatic next_frame(input int x, input int y, input int w, input int h,
                             input logic [23:0] bg, input int lim);
      wait_load();
      repeat (110) @(negedge clk);
      win_x    = CW'(x);
      win_y    = CW'(y);
      win_w    = CW'(w);
      win_h    = CW'(h);
      bg_color = bg;
      nxt_lim  = lim;
      push_frame(x, y, w, h, bg, lim, 1'b1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rd_load"}, 32'(rd_load), 32'd0);
      chk({tag, "_rden"}, 32'(rden), 32'd0);
      chk({tag, "_hsync"}, 32'(hs), 32'd0);
      chk({tag, "_vsync"}, 32'(vs), 32'd0);
      chk({tag, "_den"}, 32'(den), 32'd0);
      chk({tag, "_line_start"}, 32'(ls), 32'd0);
      chk({tag, "_pixel"}, 32'(pix), 32'd0);
      chk({tag, "_underflow"}, 32'(underflow), 32'd0);
`ifdef DISP_UNDERFLOW_STAT_EN
      chk({tag, "_uf_cnt"}, 32'(uf_cnt), 32'd0);
`endif
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset("reset");
      push_frame(0, 0, 12, 8, 24'h123456, -1, 1'b0);
      rst_n = 1'b1;
      next_frame(0, 0, 12, 8, 24'h000000, -1);
      next_frame(3, 2, 4, 3, 24'h00FF00, -1);
      next_frame(3, 2, 4, 3, 24'h00FF00, -1);
      next_frame(5, 2, 4, 3, 24'h00FF00, -1);
      next_frame(0, 0, 12, 8, 24'h0000FF, 4);
      next_frame(0, 0, 12, 8, 24'h0000FF, -1);
      next_frame(10, 6, 8, 8, 24'h111111, -1);
      next_frame(2, 2, 0, 5, 24'h222222, -1);
      next_frame(1, 1, 3, 2, 24'h333333, 0);
      next_frame(1, 1, 3, 2, 24'h444444, 5);
      next_frame(1, 1, 3, 2, 24'h555555, -1);
      next_frame(0, 0, 12, 8, 24'h666666, -1);
      next_frame(0, 0, 12, 8, 24'h777777, -1);
      wait_load();
      chk("pix_q_depth", 32'(pix_q.size()), 32'd96);
`ifdef DISP_UNDERFLOW_STAT_EN
      chk("uf_cnt", 32'(uf_cnt), 32'd3);
`endif
      n = 0;
      while (!(rden && den) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!(rden && den)) begin
         total++;
         bad++;
         $display("FAIL busy_timeout: got rden=%b den=%b, expected both high mid-line", rden, den);
      end
      #2 rst_n = 1'b0;
      #1 chk_reset("async");
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
